mem_stage: RTL

- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs and issues the data-cache read or write with a dhit handshake.
- Stalls upstream until the access completes, then latches the writeback bundle, including load data, for the WB stage.
- Also tracks the sticky halt flag and a saturating count of memory-stall cycles.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage plus MEM/WB pipeline register for the 5-stage MIPS pipeline.
// The data-cache request is driven combinationally from the EX/MEM fields.
// The pipeline is stalled until dhit arrives.
// If the hit lands while the hazard unit is freezing the pipe, the load data
// is parked in held_q until the instruction can advance.
module mem_stage #(
    parameter int              ADDR_W  = 32,
    parameter int              REG_W   = 5,
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = 6'h3F,
    parameter int              CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic [ADDR_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] ex_busB,
    input  logic [REG_W-1:0]  ex_writeReg,
    input  logic              ex_rw,
    input  logic              ex_MemtoReg,
    input  logic [1:0]        ex_RegWDSel,
    input  logic [ADDR_W-1:0] ex_PCInc,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic              enable,
    input  logic              flush,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] wb_result,
    output logic [ADDR_W-1:0] wb_load,
    output logic [ADDR_W-1:0] wb_PCInc,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic              wb_rw,
    output logic              wb_MemtoReg,
    output logic [1:0]        wb_RegWDSel,
    output logic [OP_W-1:0]   wb_opcode,
    output logic              wb_halt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [OP_W-1:0] RTYPE = '0;

    typedef enum logic {IDLE, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] result;
        logic [ADDR_W-1:0] load;
        logic [ADDR_W-1:0] pcinc;
        logic [REG_W-1:0]  wreg;
        logic              rw;
        logic              m2r;
        logic [1:0]        wdsel;
        logic [OP_W-1:0]   opcode;
    } wb_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] held_q, held_d;
    wb_t               wb_q, wb_d;
    logic              halt_q, halt_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic aligned, is_mem, pending, misalign_now, load_ok;

    // Access qualification shared by the FSM, the request outputs and the MEM/WB latch
    always_comb begin
        aligned      = (ex_result[1:0] == 2'b00);
        is_mem       = ex_valid & (ex_dREN | ex_dWEN);
        misalign_now = is_mem & ~aligned;
        pending      = is_mem & ~halt_q & aligned & (state_q != DONE) & ~flush;
        load_ok      = ex_valid & ex_dREN & aligned;
    end

    // FSM state register and the held-load register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Next state: park the hit data when the pipe is frozen, release it on advance
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pending & dhit & ~enable) begin
                    state_d = DONE;
                    held_d  = dmemload;
                end
                DONE: if (enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Cache requests and stall; a load wins over a store if both are set
    always_comb begin
        dmemREN   = pending & ex_dREN;
        dmemWEN   = pending & ex_dWEN & ~ex_dREN;
        dmemaddr  = ex_result;
        dmemstore = ex_busB;
        mem_stall = pending & ~dhit;
    end

    // MEM/WB next value: flush over enable over hold; stalled advance is a bubble
    always_comb begin
        wb_d   = wb_q;
        halt_d = halt_q;
        mis_d  = 1'b0;
        if (flush) begin
            wb_d        = '0;
            wb_d.opcode = RTYPE;
        end else if (enable & mem_stall) begin
            wb_d        = '0;
            wb_d.opcode = RTYPE;
        end else if (enable) begin
            wb_d.result = ex_result;
            wb_d.pcinc  = ex_PCInc;
            wb_d.wreg   = ex_writeReg;
            wb_d.rw     = ex_rw & ex_valid;
            wb_d.m2r    = ex_MemtoReg;
            wb_d.wdsel  = ex_RegWDSel;
            wb_d.opcode = ex_opcode;
            if (!load_ok)              wb_d.load = '0;
            else if (state_q == DONE)  wb_d.load = held_q;
            else if (pending & dhit)   wb_d.load = dmemload;
            else                       wb_d.load = '0;
            mis_d = misalign_now;
        end
        if (enable & ~flush & ex_valid & (ex_opcode == HALT_OP)) halt_d = 1'b1;
    end

    // Saturating stall-cycle counter
    always_comb begin
        cnt_d = cnt_q;
        if (mem_stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    // MEM/WB register, halt flag, misalign pulse and stall counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_q        <= '0;
            wb_q.opcode <= RTYPE;
            halt_q      <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wb_q   <= wb_d;
            halt_q <= halt_d;
            mis_q  <= mis_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wb_result   = wb_q.result;
    assign wb_load     = wb_q.load;
    assign wb_PCInc    = wb_q.pcinc;
    assign wb_writeReg = wb_q.wreg;
    assign wb_rw       = wb_q.rw;
    assign wb_MemtoReg = wb_q.m2r;
    assign wb_RegWDSel = wb_q.wdsel;
    assign wb_opcode   = wb_q.opcode;
    assign wb_halt     = halt_q;
    assign misalign    = mis_q;
    assign stall_cnt   = cnt_q;

endmodule
